// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - port bundle for the register file write arbiter
// Master drives pipeline/aux/read-address inputs; slave is the arbiter.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_waddr;
  logic [DATA_W-1:0] pipe_wdata;
  logic              aux_valid;
  logic              aux_ready;
  logic [ADDR_W-1:0] aux_waddr;
  logic [DATA_W-1:0] aux_wdata;
  logic [ADDR_W-1:0] read_address1;
  logic [ADDR_W-1:0] read_address2;
  logic              busy1;
  logic              busy2;
  logic              stall_req;
  logic              write_enable;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_data;

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata,
    output aux_valid, aux_waddr, aux_wdata,
    output read_address1, read_address2,
    input  aux_ready, busy1, busy2, stall_req,
    input  write_enable, write_address, write_data
  );

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata,
    input  aux_valid, aux_waddr, aux_wdata,
    input  read_address1, read_address2,
    output aux_ready, busy1, busy2, stall_req,
    output write_enable, write_address, write_data
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - merges pipeline write-back and aux results onto one regfile write port
// Aux results wait in a small FIFO; younger pipeline writes invalidate stale entries in place.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]  ent_valid;
  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [CNT_W-1:0]  pop_n;
  logic [CNT_W-1:0]  pop_eff;
  logic [PTR_W-1:0]  pop_idx;
  logic              head_found;
  logic              pipe_hit;
  logic              aux_fire;
  logic              aux_kill;
  logic              do_bypass;
  logic              do_push;

  assign pipe_hit = bus.pipe_we && (bus.pipe_waddr != '0);
  assign aux_fire = bus.aux_valid && bus.aux_ready;
  assign aux_kill = pipe_hit && (bus.aux_waddr == bus.pipe_waddr);

  // Walk from head: leading invalidated slots are freed along with the first live entry.
  always_comb begin
    pop_n      = '0;
    pop_idx    = head;
    head_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!head_found && (CNT_W'(i) < count)) begin
        pop_n = pop_n + CNT_W'(1);
        if (ent_valid[head + PTR_W'(i)]) begin
          head_found = 1'b1;
          pop_idx    = head + PTR_W'(i);
        end
      end
    end
  end

  always_comb begin
    pop_eff   = '0;
    do_bypass = 1'b0;
    do_push   = 1'b0;
    if (!pipe_hit) pop_eff = pop_n;
    if (aux_fire && (bus.aux_waddr != '0) && !aux_kill) begin
      if (!pipe_hit && !head_found) do_bypass = 1'b1;
      else                          do_push   = 1'b1;
    end
    count_next = count - pop_eff + CNT_W'(do_push);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      ent_valid     <= '0;
      bus.aux_ready <= 1'b0;
      bus.stall_req <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pipe_hit && ent_valid[i] && (ent_addr[i] == bus.pipe_waddr))
          ent_valid[i] <= 1'b0;
        if (CNT_W'(i) < pop_eff)
          ent_valid[head + PTR_W'(i)] <= 1'b0;
      end
      if (do_push) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PTR_W'(1);
      end
      head          <= head + PTR_W'(pop_eff);
      count         <= count_next;
      bus.aux_ready <= count_next < CNT_W'(DEPTH);
      bus.stall_req <= count_next == CNT_W'(DEPTH);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      ent_addr[tail] <= bus.aux_waddr;
      ent_data[tail] <= bus.aux_wdata;
    end
  end

  // When nothing is selected the address/data hold their last value.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.write_enable  <= 1'b0;
      bus.write_address <= '0;
      bus.write_data    <= '0;
    end else if (pipe_hit) begin
      bus.write_enable  <= 1'b1;
      bus.write_address <= bus.pipe_waddr;
      bus.write_data    <= bus.pipe_wdata;
    end else if (head_found) begin
      bus.write_enable  <= 1'b1;
      bus.write_address <= ent_addr[pop_idx];
      bus.write_data    <= ent_data[pop_idx];
    end else if (do_bypass) begin
      bus.write_enable  <= 1'b1;
      bus.write_address <= bus.aux_waddr;
      bus.write_data    <= bus.aux_wdata;
    end else begin
      bus.write_enable  <= 1'b0;
    end
  end

  always_comb begin
    bus.busy1 = 1'b0;
    bus.busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i] == bus.read_address1)) bus.busy1 = 1'b1;
      if (ent_valid[i] && (ent_addr[i] == bus.read_address2)) bus.busy2 = 1'b1;
    end
    if (bus.read_address1 == '0) bus.busy1 = 1'b0;
    if (bus.read_address2 == '0) bus.busy2 = 1'b0;
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic last_fire;
  logic [36:0] exp_q [$];

  always #5 clock = ~clock;

  regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic tick();
    last_fire = bus.aux_valid && bus.aux_ready;
    @(posedge clock);
    #1;
    if (last_fire) bus.aux_valid = 1'b0;
  endtask

  task automatic pipe(input logic we, input logic [4:0] a, input logic [31:0] d);
    bus.pipe_we = we; bus.pipe_waddr = a; bus.pipe_wdata = d;
  endtask

  task automatic aux(input logic [4:0] a, input logic [31:0] d);
    bus.aux_valid = 1'b1; bus.aux_waddr = a; bus.aux_wdata = d;
  endtask

  // Monitor: every write the DUT presents must match the head of the expected queue.
  always @(negedge clock) begin
    if (bus.write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {bus.write_address, bus.write_data}, 37'h0);
        if ({bus.write_address, bus.write_data} == 37'h0) begin
          n_bad++;
          $display("FAIL unexpected_write: got r0 write, required none");
        end
      end else begin
        check("write_port", {bus.write_address, bus.write_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    pipe(1'b1, 5'd1, 32'hDEAD_BEEF);
    bus.aux_valid = 1'b0; bus.aux_waddr = '0; bus.aux_wdata = '0;
    bus.read_address1 = '0; bus.read_address2 = '0;

    // Reset held two cycles with pipe_we asserted
    tick(); tick();
    check("rst_we",    37'(bus.write_enable), 37'd0);
    check("rst_addr",  37'(bus.write_address), 37'd0);
    check("rst_data",  37'(bus.write_data), 37'd0);
    check("rst_ready", 37'(bus.aux_ready), 37'd0);
    check("rst_stall", 37'(bus.stall_req), 37'd0);
    reset = 1'b0;
    pipe(1'b0, 5'd0, 32'd0);
    tick();
    check("ready_after_rst", 37'(bus.aux_ready), 37'd1);

    // Bypass into empty FIFO
    bus.read_address1 = 5'd3;
    aux(5'd3, 32'h1234_5678);
    expect_wr(5'd3, 32'h1234_5678);
    check("byp_busy_pre", 37'(bus.busy1), 37'd0);
    tick();
    check("byp_busy_post", 37'(bus.busy1), 37'd0);
    check("byp_we", 37'(bus.write_enable), 37'd1);
    tick();
    check("byp_we_drop", 37'(bus.write_enable), 37'd0);

    // Fill FIFO behind pipeline writes, then drain with push+pop
    bus.read_address1 = 5'd8; bus.read_address2 = 5'd9;
    pipe(1'b1, 5'd1, 32'h101); aux(5'd8, 32'hA);
    expect_wr(5'd1, 32'h101);
    tick();
    check("fill1_ready", 37'(bus.aux_ready), 37'd1);
    pipe(1'b1, 5'd2, 32'h202); aux(5'd9, 32'hB);
    expect_wr(5'd2, 32'h202);
    tick();
    check("full_stall", 37'(bus.stall_req), 37'd1);
    check("full_ready", 37'(bus.aux_ready), 37'd0);
    check("full_busy1", 37'(bus.busy1), 37'd1);
    check("full_busy2", 37'(bus.busy2), 37'd1);
    pipe(1'b1, 5'd3, 32'h303); aux(5'd10, 32'hC);
    expect_wr(5'd3, 32'h303);
    tick();
    pipe(1'b1, 5'd4, 32'h404);
    expect_wr(5'd4, 32'h404);
    tick();
    check("full_hold_stall", 37'(bus.stall_req), 37'd1);
    check("full_hold_valid", 37'(bus.aux_valid), 37'd1);
    pipe(1'b0, 5'd0, 32'd0);
    expect_wr(5'd8, 32'hA);
    tick();
    check("drain_stall", 37'(bus.stall_req), 37'd0);
    check("drain_ready", 37'(bus.aux_ready), 37'd1);
    check("drain_busy1", 37'(bus.busy1), 37'd0);
    expect_wr(5'd9, 32'hB);
    tick();
    check("pushpop_busy2", 37'(bus.busy2), 37'd0);
    check("pushpop_stall", 37'(bus.stall_req), 37'd0);
    expect_wr(5'd10, 32'hC);
    tick();
    tick();

    // Younger pipeline write kills a queued aux entry
    bus.read_address1 = 5'd5;
    pipe(1'b1, 5'd6, 32'h66); aux(5'd5, 32'h11);
    expect_wr(5'd6, 32'h66);
    tick();
    check("kill_busy_pre", 37'(bus.busy1), 37'd1);
    pipe(1'b1, 5'd5, 32'h22);
    expect_wr(5'd5, 32'h22);
    tick();
    check("kill_busy_post", 37'(bus.busy1), 37'd0);
    pipe(1'b0, 5'd0, 32'd0);
    tick(); tick();
    check("kill_ready", 37'(bus.aux_ready), 37'd1);

    // Same-cycle pipe and aux to the same register
    pipe(1'b1, 5'd7, 32'h77); aux(5'd7, 32'h99);
    expect_wr(5'd7, 32'h77);
    tick();
    check("same_ready", 37'(bus.aux_ready), 37'd1);
    pipe(1'b0, 5'd0, 32'd0);
    tick(); tick();

    // r0 writes from both sources are dropped
    pipe(1'b1, 5'd0, 32'h5555); aux(5'd0, 32'h6666);
    tick();
    check("r0_we", 37'(bus.write_enable), 37'd0);
    pipe(1'b0, 5'd0, 32'd0);
    tick();
    check("r0_stall", 37'(bus.stall_req), 37'd0);
    check("r0_ready", 37'(bus.aux_ready), 37'd1);

    // Reset with two entries queued discards them
    pipe(1'b1, 5'd11, 32'hB0B); aux(5'd12, 32'hC0C);
    expect_wr(5'd11, 32'hB0B);
    tick();
    pipe(1'b1, 5'd13, 32'hD0D); aux(5'd14, 32'hE0E);
    expect_wr(5'd13, 32'hD0D);
    tick();
    check("pre_rst_stall", 37'(bus.stall_req), 37'd1);
    pipe(1'b0, 5'd0, 32'd0);
    reset = 1'b1;
    tick();
    check("mid_rst_we", 37'(bus.write_enable), 37'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("post_rst_stall", 37'(bus.stall_req), 37'd0);
    check("post_rst_ready", 37'(bus.aux_ready), 37'd1);

    @(negedge clock);
    check("queue_drained", 37'(exp_q.size()), 37'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
